// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM states, the packed
// enable/flush control word and the load-use detector.
package hazard_pkg;

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_RUN     = 3'd1,
        ST_MEMWAIT = 3'd2
    } hz_state_t;

    // Instruction the IF/ID buffer loads when flushed (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } hz_ctrl_t;

    // Bit order: pc, ifid, idex, exmem, memwb enables, then ifid..memwb flushes.
    localparam hz_ctrl_t CTRL_FILL   = 9'b0_1111_1111;
    localparam hz_ctrl_t CTRL_RUN    = 9'b1_1111_0000;
    localparam hz_ctrl_t CTRL_FREEZE = 9'b0_0000_0000;
    localparam hz_ctrl_t CTRL_BRANCH = 9'b1_1111_1110;
    localparam hz_ctrl_t CTRL_STALL  = 9'b0_0111_0100;

    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    function automatic logic is_load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/evt_counter.sv
// Free-running event counter: advances by one on each cycle with i_inc high and
// wraps silently at 2^W.
module evt_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: drives PC and pipeline-buffer
// enables/flushes for reset fill, load-use stalls, taken branches and dmem waits.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FILL_CYCLES  = 4,
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout
);

    localparam int FILL_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(WAIT_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = '1;

    hz_state_t         r_state;
    logic [FILL_W-1:0] r_fill_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err_timeout;

    hz_state_t         w_state_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_timeout_hit;
    logic              w_stall_inc;
    logic              w_flush_inc;
    hz_ctrl_t          w_ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_FILL;
            r_fill_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fill_cnt    <= w_fill_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_err_timeout <= r_err_timeout | w_timeout_hit;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_ctrl        = CTRL_FILL;
        w_state_nxt   = ST_FILL;
        w_fill_nxt    = r_fill_cnt + FILL_W'(1);
        w_wait_nxt    = '0;
        w_timeout_hit = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;

        case (r_state)
            ST_RUN, ST_MEMWAIT: begin
                w_fill_nxt = '0;
                if (dmem_busy) begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = ST_MEMWAIT;
                    if (r_state == ST_RUN) begin
                        w_wait_nxt = WAIT_W'(1);
                    end else if (r_wait_cnt == WAIT_SAT) begin
                        w_wait_nxt = WAIT_SAT;
                    end else begin
                        w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                    end
                    w_timeout_hit = (w_wait_nxt >= WAIT_LIM);
                end else begin
                    // Release cycle of a wait decodes exactly like a RUN cycle, so a
                    // branch frozen in MEM flushes here.
                    w_state_nxt = ST_RUN;
                    if (mem_branch_taken) begin
                        w_ctrl      = CTRL_BRANCH;
                        w_flush_inc = 1'b1;
                    end else if (is_load_use(ex_mem_read, ex_rd, id_rs1, id_rs2)) begin
                        w_ctrl      = CTRL_STALL;
                        w_stall_inc = 1'b1;
                    end else begin
                        w_ctrl = CTRL_RUN;
                    end
                end
            end
            default: begin
                // FILL, and any unknown encoding, pumps bubbles until the count expires.
                if (r_fill_cnt == FILL_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_fill_nxt  = '0;
                end
            end
        endcase
    end

    evt_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    evt_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_inc (w_flush_inc),
        .o_cnt (flush_cnt)
    );

    assign pc_en       = w_ctrl.pc_en;
    assign ifid_en     = w_ctrl.ifid_en;
    assign idex_en     = w_ctrl.idex_en;
    assign exmem_en    = w_ctrl.exmem_en;
    assign memwb_en    = w_ctrl.memwb_en;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_flush  = w_ctrl.idex_flush;
    assign exmem_flush = w_ctrl.exmem_flush;
    assign memwb_flush = w_ctrl.memwb_flush;
    assign state_o     = r_state;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected per-cycle
// outputs; a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    localparam int CW = 3;

    localparam logic [2:0] S_FILL = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;

    // {pc, ifid, idex, exmem, memwb} enables and {ifid, idex, exmem, memwb} flushes
    localparam logic [4:0] E_FILL = 5'b01111;
    localparam logic [4:0] E_ALL  = 5'b11111;
    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_LU   = 5'b00111;
    localparam logic [3:0] F_ALL  = 4'b1111;
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_LU   = 4'b0100;
    localparam logic [3:0] F_BR   = 4'b1110;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          ex_mem_read, mem_branch_taken, dmem_busy;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [2:0]    state_o;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          err_timeout;

    typedef struct {
        logic [2:0]    st;
        logic [4:0]    en;
        logic [3:0]    fl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .FILL_CYCLES  (4),
        .WAIT_TIMEOUT (4),
        .CNT_W        (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .mem_branch_taken (mem_branch_taken),
        .dmem_busy        (dmem_busy),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .idex_en          (idex_en),
        .exmem_en         (exmem_en),
        .memwb_en         (memwb_en),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .memwb_flush      (memwb_flush),
        .state_o          (state_o),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt),
        .err_timeout      (err_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue what that cycle must show.
    task automatic step(
        input logic r, input logic mr, input logic [4:0] rd, input logic [4:0] r1,
        input logic [4:0] r2, input logic br, input logic bz,
        input logic [2:0] st, input logic [4:0] en, input logic [3:0] fl,
        input logic [CW-1:0] sc, input logic [CW-1:0] fc, input logic er
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        ex_mem_read      = mr;
        ex_rd            = rd;
        id_rs1           = r1;
        id_rs2           = r2;
        mem_branch_taken = br;
        dmem_busy        = bz;
        e.st  = st;
        e.en  = en;
        e.fl  = fl;
        e.sc  = sc;
        e.fc  = fc;
        e.err = er;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("state",   32'(state_o), 32'(mon_e.st));
                check("enables", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(mon_e.en));
                check("flushes", 32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'(mon_e.fl));
                check("stall_cnt",   32'(stall_cnt),   32'(mon_e.sc));
                check("flush_cnt",   32'(flush_cnt),   32'(mon_e.fc));
                check("err_timeout", 32'(err_timeout), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        mem_branch_taken = 1'b0; dmem_busy = 1'b0;

        // Reset held, then release: four fill cycles before RUN.
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, S_FILL, E_FILL, F_ALL, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, S_FILL, E_FILL, F_ALL, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, S_RUN, E_ALL, F_NONE, 0, 0, 0);

        // Load-use via rs2, then non-hazards (x0 destination, non-load).
        step(1, 1, 5, 3, 5, 0, 0, S_RUN, E_LU,  F_LU,   0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, S_RUN, E_ALL, F_NONE, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, S_RUN, E_ALL, F_NONE, 1, 0, 0);
        step(1, 0, 7, 7, 7, 0, 0, S_RUN, E_ALL, F_NONE, 1, 0, 0);

        // Repeated load-use via rs1 until stall_cnt wraps 7 -> 0.
        for (int i = 0; i < 7; i++) step(1, 1, 7, 7, 2, 0, 0, S_RUN, E_LU, F_LU, 3'(1 + i), 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, S_RUN, E_ALL, F_NONE, 0, 0, 0);

        // Branch beats a simultaneous load-use.
        step(1, 1, 5, 5, 1, 1, 0, S_RUN, E_ALL, F_BR,   0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, S_RUN, E_ALL, F_NONE, 0, 1, 0);

        // Three busy cycles with a branch frozen in MEM; flush on release.
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 1, 1, (i == 0) ? S_RUN : S_WAIT, E_NONE, F_NONE, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0, S_WAIT, E_ALL, F_BR,   0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, S_RUN,  E_ALL, F_NONE, 0, 2, 0);

        // Load-use seen on a wait release cycle.
        step(1, 0, 0, 0, 0, 0, 1, S_RUN,  E_NONE, F_NONE, 0, 2, 0);
        step(1, 1, 9, 4, 9, 0, 0, S_WAIT, E_LU,   F_LU,   0, 2, 0);
        step(1, 0, 0, 0, 0, 0, 0, S_RUN,  E_ALL,  F_NONE, 1, 2, 0);

        // Six busy cycles against a timeout of four: sticky error.
        for (int i = 0; i < 6; i++)
            step(1, 0, 0, 0, 0, 0, 1, (i == 0) ? S_RUN : S_WAIT, E_NONE, F_NONE, 1, 2, (i >= 4));
        step(1, 0, 0, 0, 0, 0, 0, S_WAIT, E_ALL,  F_NONE, 1, 2, 1);
        step(1, 0, 0, 0, 0, 0, 0, S_RUN,  E_ALL,  F_NONE, 1, 2, 1);
        step(1, 0, 0, 0, 0, 0, 1, S_RUN,  E_NONE, F_NONE, 1, 2, 1);
        step(1, 0, 0, 0, 0, 0, 1, S_WAIT, E_NONE, F_NONE, 1, 2, 1);

        // Reset pulse mid-wait clears everything; hazards are ignored while filling.
        step(0, 0, 0, 0, 0, 0, 1, S_FILL, E_FILL, F_ALL, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 5, 5, 5, 1, 0, S_FILL, E_FILL, F_ALL, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, S_RUN, E_ALL, F_NONE, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
